// File: rtl/cpu_bus_arbiter.sv
// Shares a single-port synchronous RAM between the CPU and a cycle-stealing DMA engine.
// DMA may take at most MAX_STEAL consecutive cycles before the CPU is handed one cycle back.
module cpu_bus_arbiter #(
   parameter int MAX_STEAL = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ready,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic        dma_write,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic        dma_rvalid,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   localparam logic [3:0] MAX_CNT  = 4'(MAX_STEAL);
   localparam logic [1:0] ST_CPU   = 2'd0;
   localparam logic [1:0] ST_STEAL = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;

   logic [1:0] state;
   logic [1:0] state_next;
   logic [3:0] steal_cnt;
   logic [3:0] cnt_next;
   logic       idle_dma;
   logic       rvalid_q;

   // A CPU write can never be stalled, and once the burst limit is reached the count blocks DMA for one cycle.
   assign dma_ack = dma_req & ~cpu_write & ~reset & (steal_cnt < MAX_CNT) & ~idle_dma;

   assign cpu_ready = ~dma_ack;
   assign mem_addr  = dma_ack ? dma_addr  : cpu_addr;
   assign mem_we    = dma_ack ? dma_write : cpu_write;
   assign mem_wdata = dma_ack ? dma_wdata : cpu_wdata;
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   // Masking with reset drops read data belonging to a grant made just before reset arrived.
   assign dma_rvalid = rvalid_q & ~reset;

   always_comb begin
      cnt_next   = 4'd0;
      state_next = ST_CPU;
      case (state)
         ST_CPU, ST_STEAL: begin
            if (dma_ack) begin
               cnt_next   = steal_cnt + 4'd1;
               state_next = (cnt_next == MAX_CNT) ? ST_FORCE : ST_STEAL;
            end
         end
         default: begin
            cnt_next   = 4'd0;
            state_next = ST_CPU;
         end
      endcase
   end

   // idle_dma holds DMA off for the cycle after reset so the CPU can fetch its reset vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_CPU;
         steal_cnt <= 4'd0;
         rvalid_q  <= 1'b0;
         idle_dma  <= 1'b1;
      end else begin
         state     <= state_next;
         steal_cnt <= cnt_next;
         rvalid_q  <= dma_ack & ~dma_write;
         idle_dma  <= 1'b0;
      end
   end

endmodule
